// File: rtl/id_ex_if.sv
// Bus bundle between the ID stage, the ID/EX register and the EX stage.
// The slave modport is the ID/EX stage itself; the master modport is whoever drives ID and forwarding.
interface id_ex_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic [DATA_WIDTH-1:0]     id_rs1_data;
  logic [DATA_WIDTH-1:0]     id_rs2_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [1:0]                id_alu_op;
  logic [2:0]                id_funct3;
  logic                      id_funct7b5;
  logic                      id_alu_src;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic                      id_mem_to_reg;
  logic                      stall;
  logic                      flush;
  logic                      exmem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] exmem_rd;
  logic [DATA_WIDTH-1:0]     exmem_result;
  logic                      memwb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] memwb_rd;
  logic [DATA_WIDTH-1:0]     memwb_result;

  logic                      load_use_stall;
  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     data1;
  logic [DATA_WIDTH-1:0]     data2;
  logic [3:0]                ALU_control;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic                      ex_mem_to_reg;

  modport slave (
    input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_funct3, id_funct7b5, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output load_use_stall, ex_valid, data1, data2, ALU_control, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
  );

  modport master (
    output id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_alu_op, id_funct3, id_funct7b5, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           stall, flush,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  load_use_stall, ex_valid, data1, data2, ALU_control, ex_store_data,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, load-use bubble insertion
// and EX/MEM, MEM/WB operand forwarding in front of the ALU.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic   clk,
  input logic   reset,
  id_ex_if.slave bus
);
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  logic                      ex_valid_reg;
  logic [DATA_WIDTH-1:0]     rs1_data_reg;
  logic [DATA_WIDTH-1:0]     rs2_data_reg;
  logic [DATA_WIDTH-1:0]     imm_reg;
  logic [REG_ADDR_WIDTH-1:0] rs1_reg;
  logic [REG_ADDR_WIDTH-1:0] rs2_reg;
  logic [REG_ADDR_WIDTH-1:0] rd_reg;
  logic                      alu_src_reg;
  logic                      reg_write_reg;
  logic                      mem_read_reg;
  logic                      mem_write_reg;
  logic                      mem_to_reg_reg;
  logic [3:0]                alu_ctrl_reg;
  logic [3:0]                alu_ctrl_next;
  logic                      load_use;
  logic                      bubble;

  always_comb begin
    alu_ctrl_next = ALU_NOP;
    case (bus.id_alu_op)
      2'b00: alu_ctrl_next = ALU_ADD;
      2'b01: alu_ctrl_next = ALU_SUB;
      2'b10: begin
        case (bus.id_funct3)
          3'b000:  alu_ctrl_next = (bus.id_funct7b5 && !bus.id_alu_src) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl_next = ALU_AND;
          3'b110:  alu_ctrl_next = ALU_OR;
          default: alu_ctrl_next = ALU_NOP;
        endcase
      end
      default: alu_ctrl_next = ALU_NOP;
    endcase
  end

  // A load in EX cannot forward its data in time; an immediate-sourced rs2 is not a real use.
  assign load_use = bus.id_valid && ex_valid_reg && mem_read_reg && (rd_reg != '0) &&
                    ((rd_reg == bus.id_rs1) || ((rd_reg == bus.id_rs2) && !bus.id_alu_src)) &&
                    !bus.stall && !bus.flush;
  // Flush beats stall; load_use is already suppressed under stall/flush.
  assign bubble = bus.flush || load_use;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_reg   <= 1'b0;
      rs1_data_reg   <= '0;
      rs2_data_reg   <= '0;
      imm_reg        <= '0;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      rd_reg         <= '0;
      alu_src_reg    <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      alu_ctrl_reg   <= ALU_AND;
    end else if (bubble) begin
      ex_valid_reg   <= 1'b0;
      rs1_data_reg   <= '0;
      rs2_data_reg   <= '0;
      imm_reg        <= '0;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      rd_reg         <= '0;
      alu_src_reg    <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      alu_ctrl_reg   <= ALU_NOP;
    end else if (!bus.stall) begin
      ex_valid_reg   <= bus.id_valid;
      rs1_data_reg   <= bus.id_rs1_data;
      rs2_data_reg   <= bus.id_rs2_data;
      imm_reg        <= bus.id_imm;
      rs1_reg        <= bus.id_rs1;
      rs2_reg        <= bus.id_rs2;
      rd_reg         <= bus.id_rd;
      alu_src_reg    <= bus.id_alu_src;
      reg_write_reg  <= bus.id_valid && bus.id_reg_write;
      mem_read_reg   <= bus.id_valid && bus.id_mem_read;
      mem_write_reg  <= bus.id_valid && bus.id_mem_write;
      mem_to_reg_reg <= bus.id_valid && bus.id_mem_to_reg;
      alu_ctrl_reg   <= alu_ctrl_next;
    end
  end

  // Operand 0 is rs1, operand 1 is rs2; EX/MEM wins over MEM/WB, x0 is never forwarded.
  logic [REG_ADDR_WIDTH-1:0] op_rs   [2];
  logic [DATA_WIDTH-1:0]     op_data [2];
  logic [DATA_WIDTH-1:0]     op_fwd  [2];

  assign op_rs[0]   = rs1_reg;
  assign op_rs[1]   = rs2_reg;
  assign op_data[0] = rs1_data_reg;
  assign op_data[1] = rs2_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic exmem_hit;
      logic memwb_hit;
      assign exmem_hit  = bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == op_rs[gi]);
      assign memwb_hit  = bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == op_rs[gi]);
      assign op_fwd[gi] = exmem_hit ? bus.exmem_result :
                          memwb_hit ? bus.memwb_result : op_data[gi];
    end
  endgenerate

  assign bus.load_use_stall = load_use;
  assign bus.ex_valid       = ex_valid_reg;
  assign bus.data1          = op_fwd[0];
  assign bus.data2          = alu_src_reg ? imm_reg : op_fwd[1];
  assign bus.ex_store_data  = op_fwd[1];
  assign bus.ALU_control    = alu_ctrl_reg;
  assign bus.ex_rd          = rd_reg;
  assign bus.ex_reg_write   = reg_write_reg;
  assign bus.ex_mem_read    = mem_read_reg;
  assign bus.ex_mem_write   = mem_write_reg;
  assign bus.ex_mem_to_reg  = mem_to_reg_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural model of the EX-side contents predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_id_ex_stage;
  localparam int DW = 8;
  localparam int AW = 5;

  logic clk;
  logic reset;
  id_ex_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    bit [AW-1:0] rs1, rs2, rd;
    bit [DW-1:0] d1, d2, imm;
    bit          src, rw, mr, mw, m2r;
    bit [3:0]    aluc;
    bit          aluc_known;
  } ex_t;

  typedef struct {
    bit          lus;
    bit          valid;
    bit [DW-1:0] data1, data2, store;
    bit [3:0]    aluc;
    bit          aluc_known;
    bit [AW-1:0] rd;
    bit [3:0]    ctl;
  } exp_t;

  ex_t  st;
  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [3:0] decode(bit [1:0] op, bit [2:0] f3, bit f7, bit src);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (op == 2'd3) return 4'd15;
    if (f3 == 3'd0) return (f7 && !src) ? 4'd6 : 4'd2;
    if (f3 == 3'd7) return 4'd0;
    if (f3 == 3'd6) return 4'd1;
    return 4'd15;
  endfunction

  function automatic bit [DW-1:0] fwd(bit [AW-1:0] rs, bit [DW-1:0] regval);
    if (bus.exmem_reg_write && bus.exmem_rd != 0 && bus.exmem_rd == rs) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == rs) return bus.memwb_result;
    return regval;
  endfunction

  function automatic bit model_lus();
    return bus.id_valid && st.valid && st.mr && st.rd != 0 &&
           (st.rd == bus.id_rs1 || (st.rd == bus.id_rs2 && !bus.id_alu_src)) &&
           !bus.stall && !bus.flush && !reset;
  endfunction

  function automatic ex_t zero_state(bit [3:0] aluc);
    ex_t z;
    z = '{default: 0};
    z.aluc = aluc;
    z.aluc_known = 1'b1;
    return z;
  endfunction

  task automatic push_expect();
    exp_t e;
    e.lus        = model_lus();
    e.valid      = st.valid;
    e.data1      = fwd(st.rs1, st.d1);
    e.store      = fwd(st.rs2, st.d2);
    e.data2      = st.src ? st.imm : e.store;
    e.aluc       = st.aluc;
    e.aluc_known = st.aluc_known;
    e.rd         = st.rd;
    e.ctl        = {st.rw, st.mr, st.mw, st.m2r};
    q.push_back(e);
  endtask

  // Apply one clock edge to the model using the inputs held across that edge.
  task automatic model_edge();
    if (reset) st = zero_state(4'd0);
    else if (bus.flush || model_lus()) st = zero_state(4'd15);
    else if (!bus.stall) begin
      st.valid      = bus.id_valid;
      st.rs1        = bus.id_rs1;
      st.rs2        = bus.id_rs2;
      st.rd         = bus.id_rd;
      st.d1         = bus.id_rs1_data;
      st.d2         = bus.id_rs2_data;
      st.imm        = bus.id_imm;
      st.src        = bus.id_alu_src;
      st.rw         = bus.id_valid & bus.id_reg_write;
      st.mr         = bus.id_valid & bus.id_mem_read;
      st.mw         = bus.id_valid & bus.id_mem_write;
      st.m2r        = bus.id_valid & bus.id_mem_to_reg;
      st.aluc       = decode(bus.id_alu_op, bus.id_funct3, bus.id_funct7b5, bus.id_alu_src);
      st.aluc_known = bus.id_valid;
    end
  endtask

  task automatic cycle();
    push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("load_use_stall", int'(bus.load_use_stall), int'(e.lus));
      chk("ex_valid", int'(bus.ex_valid), int'(e.valid));
      chk("data1", int'(bus.data1), int'(e.data1));
      chk("data2", int'(bus.data2), int'(e.data2));
      chk("ex_store_data", int'(bus.ex_store_data), int'(e.store));
      chk("ex_rd", int'(bus.ex_rd), int'(e.rd));
      chk("ex_ctl", int'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg}),
          int'(e.ctl));
      if (e.aluc_known) chk("ALU_control", int'(bus.ALU_control), int'(e.aluc));
    end
  end

  task automatic set_defaults();
    bus.id_valid = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0; bus.id_alu_op = 0; bus.id_funct3 = 0;
    bus.id_funct7b5 = 0; bus.id_alu_src = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.id_mem_write = 0; bus.id_mem_to_reg = 0; bus.stall = 0; bus.flush = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic rand_id();
    bus.id_valid = ($urandom_range(0, 7) != 0);
    bus.id_rs1_data = DW'($urandom); bus.id_rs2_data = DW'($urandom); bus.id_imm = DW'($urandom);
    bus.id_rs1 = AW'($urandom_range(0, 7)); bus.id_rs2 = AW'($urandom_range(0, 7));
    bus.id_rd = AW'($urandom_range(0, 7));
    bus.id_alu_op = 2'($urandom); bus.id_funct3 = 3'($urandom); bus.id_funct7b5 = 1'($urandom);
    bus.id_alu_src = 1'($urandom); bus.id_reg_write = 1'($urandom);
    bus.id_mem_read = ($urandom_range(0, 2) == 0); bus.id_mem_write = 1'($urandom);
    bus.id_mem_to_reg = 1'($urandom);
  endtask

  task automatic rand_fwd();
    bus.exmem_reg_write = 1'($urandom); bus.exmem_rd = AW'($urandom_range(0, 7));
    bus.exmem_result = DW'($urandom);
    bus.memwb_reg_write = 1'($urandom); bus.memwb_rd = AW'($urandom_range(0, 7));
    bus.memwb_result = DW'($urandom);
  endtask

  task automatic load_id(input bit [1:0] op, input bit [2:0] f3, input bit f7, input bit src,
                         input bit [AW-1:0] rs1, input bit [AW-1:0] rs2, input bit [AW-1:0] rd,
                         input bit [DW-1:0] d1, input bit [DW-1:0] d2, input bit [DW-1:0] imm,
                         input bit mr, input bit mw);
    bus.id_valid = 1; bus.id_alu_op = op; bus.id_funct3 = f3; bus.id_funct7b5 = f7;
    bus.id_alu_src = src; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
    bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_mem_to_reg = mr;
    bus.id_reg_write = !mw;
  endtask

  initial begin
    st = zero_state(4'd0);
    reset = 1'b1;
    set_defaults();
    @(posedge clk);
    #1;
    // Reset held with garbage on ID: nothing may be captured.
    for (int i = 0; i < 2; i++) begin rand_id(); cycle(); end
    reset = 1'b0;
    set_defaults();
    // R-type SUB
    load_id(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd4, 8'h30, 8'h10, 8'h00, 1'b0, 1'b0);
    cycle();
    // Forwarding priority on EX rs1=3 (stalled so EX keeps the instruction)
    load_id(2'b10, 3'b110, 1'b0, 1'b0, 5'd3, 5'd6, 5'd4, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0);
    cycle();
    bus.stall = 1;
    bus.exmem_reg_write = 1; bus.exmem_rd = 3; bus.exmem_result = 8'h55;
    bus.memwb_reg_write = 1; bus.memwb_rd = 3; bus.memwb_result = 8'hAA;
    cycle();
    bus.exmem_reg_write = 0;
    cycle();
    bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.memwb_rd = 0;
    cycle();
    set_defaults();
    // Load-use on rs2, then the immediate-form case with no hazard
    load_id(2'b00, 3'b010, 1'b0, 1'b1, 5'd1, 5'd0, 5'd5, 8'h08, 8'h00, 8'h04, 1'b1, 1'b0);
    cycle();
    load_id(2'b10, 3'b000, 1'b0, 1'b0, 5'd2, 5'd5, 5'd6, 8'h01, 8'h02, 8'h00, 1'b0, 1'b0);
    cycle();
    cycle();
    load_id(2'b00, 3'b010, 1'b0, 1'b1, 5'd1, 5'd0, 5'd5, 8'h08, 8'h00, 8'h04, 1'b1, 1'b0);
    cycle();
    load_id(2'b10, 3'b000, 1'b0, 1'b1, 5'd2, 5'd5, 5'd6, 8'h01, 8'h02, 8'h07, 1'b0, 1'b0);
    cycle();
    // Stall three cycles while ID churns, then stall+flush together
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin rand_id(); cycle(); end
    bus.flush = 1;
    cycle();
    set_defaults();
    // Store with MEM/WB forwarding of rs2
    load_id(2'b00, 3'b010, 1'b0, 1'b1, 5'd1, 5'd7, 5'd0, 8'h20, 8'h01, 8'h04, 1'b0, 1'b1);
    cycle();
    bus.memwb_reg_write = 1; bus.memwb_rd = 7; bus.memwb_result = 8'h9C;
    cycle();
    // Asynchronous reset mid-cycle while EX holds a valid instruction
    set_defaults();
    load_id(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0);
    cycle();
    chk("pre_reset_ex_valid", int'(bus.ex_valid), 1);
    #1 reset = 1'b1;
    #1;
    chk("async_ex_valid", int'(bus.ex_valid), 0);
    chk("async_ex_reg_write", int'(bus.ex_reg_write), 0);
    st = zero_state(4'd0);
    cycle();
    reset = 1'b0;
    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      rand_id();
      rand_fwd();
      bus.stall = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      cycle();
    end
    set_defaults();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-select stage sitting directly upstream of the 8-bit ALU. Captures decoded ID-stage operands and control, decodes the 4-bit ALU_control, and applies EX/MEM and MEM/WB forwarding to drive the ALU's data1/data2. Detects load-use hazards, inserting bubbles, and supports external stall and flush.

Parameters:
DATA_WIDTH, 8, operand/result width
REG_ADDR_WIDTH, 5, register specifier width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs1_data, id_rs2_data  in  DATA_WIDTH  register file read data
id_imm  in  DATA_WIDTH  sign-extended/truncated immediate
id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  register specifiers
id_alu_op  in  2  00 mem-addr, 01 branch, 10 R/I arithmetic, 11 reserved
id_funct3  in  3  instruction funct3
id_funct7b5  in  1  instruction bit 30
id_alu_src  in  1  1 = data2 from immediate (I-type/load/store)
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  each; ID control
stall  in  1  hold this register (downstream/memory stall)
flush  in  1  kill instruction entering EX (taken branch)
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  REG_ADDR_WIDTH  EX/MEM destination
exmem_result  in  DATA_WIDTH  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  REG_ADDR_WIDTH  MEM/WB destination
memwb_result  in  DATA_WIDTH  MEM/WB writeback value
load_use_stall  out  1  combinational; ID/IF must hold this cycle
ex_valid  out  1  EX holds a real instruction
data1, data2  out  DATA_WIDTH  ALU operands
ALU_control  out  4  ALU operation code
ex_store_data  out  DATA_WIDTH  forwarded rs2 for stores
ex_rd  out  REG_ADDR_WIDTH  registered destination
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  each; registered control

Behaviour:
- Reset (async, immediate): all registered fields 0; ex_valid=0, all ex_* control 0, ALU_control=0000 (AND); data1/data2 then follow forwarding rules on zeroed regs.
- Per-edge priority: reset > flush > stall > load_use_stall > normal capture.
  - flush: load bubble (ex_valid=0, reg_write/mem_read/mem_write/mem_to_reg=0, ALU_control=1111, data fields don't-care but set 0). Flush overrides stall.
  - stall (no flush): every registered field holds.
  - load_use_stall (no flush/stall): load bubble as above.
  - normal: capture all id_* fields; ex_valid<=id_valid; if id_valid=0 control bits load as 0.
- load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | (ex_rd==id_rs2 & !id_alu_src)) & !stall & !flush.
- ALU_control decoded from ID fields at capture, registered (one-cycle latency ID->EX):
  - alu_op 00 -> 0010 (ADD); 01 -> 0110 (SUB).
  - alu_op 10: funct3 000 -> 0110 if (funct7b5 & !alu_src) else 0010; 111 -> 0000; 110 -> 0001; other -> 1111.
  - alu_op 11 -> 1111 (ALU outputs 0).
- Forwarding (combinational on registered rs1/rs2):
  - fwd_rsN = exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==rsN;
    else memwb_result if memwb_reg_write & memwb_rd!=0 & memwb_rd==rsN;
    else registered rsN data. EX/MEM has priority.
- data1 = fwd_rs1; data2 = alu_src ? imm : fwd_rs2; ex_store_data = fwd_rs2.
- Arithmetic all DATA_WIDTH, no width change; x0 never forwarded.
- Reset mid-operation: pending bubble/stall state discarded; next capture after reset release is normal.

Test Plan:
- Reset then capture id_alu_op=10, funct3=000, funct7b5=1, alu_src=0, rs1_data=0x30, rs2_data=0x10 -> next cycle ALU_control=0110, data1=0x30, data2=0x10, ex_valid=1.
- EX rs1=3; exmem_rd=3 (0x55, reg_write=1) and memwb_rd=3 (0xAA) -> data1=0x55; clear exmem_reg_write -> data1=0xAA; rd=0 on both -> registered data.
- EX holds load to rd=5 (mem_read=1); ID R-type rs2=5 -> load_use_stall=1; next edge ex_valid=0, controls 0, ALU_control=1111; ID with alu_src=1 and rs2=5 only -> no stall.
- stall=1 for 3 cycles while id_* changes -> all ex_* outputs unchanged; stall=1 and flush=1 same edge -> bubble loaded.
- Store: alu_src=1, imm=0x04, rs2=7, memwb_rd=7 result 0x9C -> data2=0x04, ex_store_data=0x9C, ALU_control=0010.
- Assert reset asynchronously mid-cycle with ex_valid=1 -> ex_valid and ex_reg_write drop to 0 before next clock edge.
